// File: rtl/backend_types.sv
// Shared rename-backend types: checkpoint (COB) sizing, RAT entry and checkpoint entry layouts.
package backend_types;

   localparam int COB_DEPTH          = 4;
   localparam int COB_TAG_WIDTH      = $clog2(COB_DEPTH);
   localparam int NUM_ARCH_REGISTERS = 32;
   localparam int ARCH_IDX_WIDTH     = $clog2(NUM_ARCH_REGISTERS);
   localparam int PHYS_REG_WIDTH     = 6;

   typedef struct packed {
      logic                      valid;
      logic [PHYS_REG_WIDTH-1:0] data;
   } rat_entry_t;

   typedef struct packed {
      rat_entry_t [NUM_ARCH_REGISTERS-1:0] rat_data;
      logic [COB_DEPTH-1:0]                branch_mask;
   } cob_entry_t;

   // Empty checkpoint: all mappings to p0 and marked ready.
   function automatic cob_entry_t cob_reset_entry();
      cob_entry_t e;
      e = '0;
      for (int k = 0; k < NUM_ARCH_REGISTERS; k++) begin
         e.rat_data[k].valid = 1'b1;
      end
      return e;
   endfunction

endpackage

// File: rtl/checkpoint_ctrl_if.sv
// Allocation, resolution and branch-broadcast handshake between dispatch/resolve logic and checkpoint_ctrl.
interface checkpoint_ctrl_if;
   import backend_types::*;

   logic                     alloc_req;
   logic                     alloc_ack;
   logic [COB_TAG_WIDTH-1:0] alloc_tag;
   logic [COB_DEPTH-1:0]     alloc_mask;
   logic                     full;

   logic                     resolve_valid;
   logic [COB_TAG_WIDTH-1:0] resolve_tag;
   logic                     resolve_kill;

   logic                     broadcast;
   logic                     kill;
   logic [COB_TAG_WIDTH-1:0] tag;

   modport master (
      output alloc_req, resolve_valid, resolve_tag, resolve_kill,
      input  alloc_ack, alloc_tag, alloc_mask, full, broadcast, kill, tag
   );

   modport slave (
      input  alloc_req, resolve_valid, resolve_tag, resolve_kill,
      output alloc_ack, alloc_tag, alloc_mask, full, broadcast, kill, tag
   );

endinterface

// File: rtl/free_tag_encoder.sv
// Lowest-index priority encoder over the free-checkpoint vector.
module free_tag_encoder #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 2
) (
   input  logic [DEPTH-1:0] free,
   output logic [TAG_W-1:0] tag,
   output logic             any_free
);

   always_comb begin
      tag      = '0;
      any_free = 1'b0;
      // Scan high to low so the lowest free index is the last one written.
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (free[i]) begin
            tag      = i[TAG_W-1:0];
            any_free = 1'b1;
         end
      end
   end

endmodule

// File: rtl/checkpoint_ctrl.sv
// Branch-checkpoint controller: allocates COB tags, snapshots the RAT, frees/flushes on resolve.
// Define CHECKPOINT_CDB_SNOOP_EN to let stored snapshots pick up CDB wakeups.
module checkpoint_ctrl
   import backend_types::*;
(
   input  logic                                clk,
   input  logic                                rst,
   checkpoint_ctrl_if.slave                    bus,
   input  rat_entry_t [NUM_ARCH_REGISTERS-1:0] rat_data,
   input  logic                                cdb_valid,
   input  logic [ARCH_IDX_WIDTH-1:0]           cdb_ard,
   input  logic [PHYS_REG_WIDTH-1:0]           cdb_prd,
   output cob_entry_t [COB_DEPTH-1:0]          cob_data
);

   logic [COB_DEPTH-1:0]       busy_q, busy_d;
   logic [COB_DEPTH-1:0]       live_q, live_d, live_after;
   cob_entry_t [COB_DEPTH-1:0] cob_q, cob_d;
   logic                       bcast_q, bcast_d;
   logic                       kill_q, kill_d;
   logic [COB_TAG_WIDTH-1:0]   tag_q, tag_d;

   logic [COB_TAG_WIDTH-1:0]   free_tag;
   logic                       any_free;
   logic                       rv_busy, mispredict, correct;
   logic [COB_DEPTH-1:0]       r_onehot, clr_mask, younger;

   free_tag_encoder #(
      .DEPTH (COB_DEPTH),
      .TAG_W (COB_TAG_WIDTH)
   ) u_free_tag_encoder (
      .free     (~busy_q),
      .tag      (free_tag),
      .any_free (any_free)
   );

   assign rv_busy    = bus.resolve_valid & busy_q[bus.resolve_tag];
   assign mispredict = rv_busy & bus.resolve_kill;
   assign correct    = rv_busy & ~bus.resolve_kill;
   assign r_onehot   = COB_DEPTH'(1) << bus.resolve_tag;
   assign clr_mask   = correct ? r_onehot : '0;
   assign live_after = live_q & ~clr_mask;

   assign bus.full       = ~any_free;
   assign bus.alloc_tag  = free_tag;
   assign bus.alloc_ack  = bus.alloc_req & any_free & ~mispredict;
   assign bus.alloc_mask = live_q;
   assign bus.broadcast  = bcast_q;
   assign bus.kill       = kill_q;
   assign bus.tag        = tag_q;
   assign cob_data       = cob_q;

   always_comb begin
      for (int j = 0; j < COB_DEPTH; j++) begin
         younger[j] = cob_q[j].branch_mask[bus.resolve_tag];
      end
   end

   always_comb begin
      busy_d  = busy_q;
      live_d  = live_after;
      cob_d   = cob_q;
      bcast_d = rv_busy;
      kill_d  = mispredict;
      tag_d   = rv_busy ? bus.resolve_tag : tag_q;

      for (int i = 0; i < COB_DEPTH; i++) begin
         cob_d[i].branch_mask = cob_q[i].branch_mask & ~clr_mask;
`ifdef CHECKPOINT_CDB_SNOOP_EN
         if (busy_q[i] && cdb_valid && (cob_q[i].rat_data[cdb_ard].data == cdb_prd)) begin
            cob_d[i].rat_data[cdb_ard].valid = 1'b1;
         end
`endif
      end

      if (correct) begin
         busy_d = busy_q & ~r_onehot;
      end
      // Flushed entries keep their storage so the RAT can reload from cob_data[tag].
      if (mispredict) begin
         busy_d = busy_q & ~(r_onehot | younger);
         live_d = cob_q[bus.resolve_tag].branch_mask;
      end

      if (bus.alloc_ack) begin
         busy_d[free_tag]                = 1'b1;
         live_d[free_tag]                = 1'b1;
         cob_d[free_tag].rat_data        = rat_data;
         cob_d[free_tag].branch_mask     = live_after;
`ifdef CHECKPOINT_CDB_SNOOP_EN
         if (cdb_valid && (rat_data[cdb_ard].data == cdb_prd)) begin
            cob_d[free_tag].rat_data[cdb_ard].valid = 1'b1;
         end
`endif
      end
   end

`ifndef CHECKPOINT_CDB_SNOOP_EN
   logic unused_cdb;
   assign unused_cdb = ^{cdb_valid, cdb_ard, cdb_prd};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= '0;
         live_q  <= '0;
         bcast_q <= 1'b0;
         kill_q  <= 1'b0;
         tag_q   <= '0;
         for (int i = 0; i < COB_DEPTH; i++) begin
            cob_q[i] <= cob_reset_entry();
         end
      end else begin
         busy_q  <= busy_d;
         live_q  <= live_d;
         bcast_q <= bcast_d;
         kill_q  <= kill_d;
         tag_q   <= tag_d;
         cob_q   <= cob_d;
      end
   end

endmodule

// File: tb/tb_checkpoint_ctrl.sv
// Directed bench for checkpoint_ctrl: allocation, correct resolve, mispredict flush, CDB snoop, reset.
module tb_checkpoint_ctrl;
   import backend_types::*;

   logic clk = 1'b0;
   logic rst;
   rat_entry_t [NUM_ARCH_REGISTERS-1:0] rat_data_s;
   logic                                cdb_valid;
   logic [ARCH_IDX_WIDTH-1:0]           cdb_ard;
   logic [PHYS_REG_WIDTH-1:0]           cdb_prd;
   cob_entry_t [COB_DEPTH-1:0]          cob_data_s;

   int n_cmp = 0;
   int n_err = 0;

   checkpoint_ctrl_if bif ();

   checkpoint_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bif.slave),
      .rat_data (rat_data_s),
      .cdb_valid(cdb_valid),
      .cdb_ard  (cdb_ard),
      .cdb_prd  (cdb_prd),
      .cob_data (cob_data_s)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag_s, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag_s, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      bif.alloc_req     = 1'b0;
      bif.resolve_valid = 1'b0;
      bif.resolve_tag   = '0;
      bif.resolve_kill  = 1'b0;
      cdb_valid         = 1'b0;
      cdb_ard           = '0;
      cdb_prd           = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      settle();
   endtask

   task automatic alloc_n(input int n);
      bif.alloc_req = 1'b1;
      for (int k = 0; k < n; k++) tick();
      bif.alloc_req = 1'b0;
      settle();
   endtask

   initial begin
      rat_data_s = '0;
      rat_data_s[5].valid = 1'b0;
      rat_data_s[5].data  = 6'd7;

      // Reset state
      do_reset();
      check("rst_full", 32'(bif.full), 32'd0);
      check("rst_mask", 32'(bif.alloc_mask), 32'd0);
      check("rst_bcast", 32'(bif.broadcast), 32'd0);
      check("rst_kill", 32'(bif.kill), 32'd0);
      check("rst_tag", 32'(bif.tag), 32'd0);
      check("rst_bm0", 32'(cob_data_s[0].branch_mask), 32'd0);
      check("rst_valid", 32'(cob_data_s[2].rat_data[5].valid), 32'd1);
      check("rst_data", 32'(cob_data_s[2].rat_data[5].data), 32'd0);

      // Fill all four checkpoints, fifth request refused
      bif.alloc_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         check("fill_ack", 32'(bif.alloc_ack), 32'd1);
         check("fill_tag", 32'(bif.alloc_tag), 32'(k));
         tick();
      end
      settle();
      check("full_flag", 32'(bif.full), 32'd1);
      check("full_noack", 32'(bif.alloc_ack), 32'd0);
      bif.alloc_req = 1'b0;
      check("fill_bm3", 32'(cob_data_s[3].branch_mask), 32'b0111);
      check("fill_bm1", 32'(cob_data_s[1].branch_mask), 32'b0001);
      check("fill_live", 32'(bif.alloc_mask), 32'b1111);
      check("fill_snap", 32'(cob_data_s[2].rat_data[5].data), 32'd7);

      // Correct resolve of tag 0
      do_reset();
      alloc_n(2);
      bif.resolve_valid = 1'b1;
      bif.resolve_tag   = 2'd0;
      bif.resolve_kill  = 1'b0;
      settle();
      check("cr_pre_bcast", 32'(bif.broadcast), 32'd0);
      tick();
      bif.resolve_valid = 1'b0;
      check("cr_bcast", 32'(bif.broadcast), 32'd1);
      check("cr_kill", 32'(bif.kill), 32'd0);
      check("cr_tag", 32'(bif.tag), 32'd0);
      check("cr_bm1", 32'(cob_data_s[1].branch_mask), 32'd0);
      check("cr_live", 32'(bif.alloc_mask), 32'b0010);
      bif.alloc_req = 1'b1;
      settle();
      check("cr_regrant_ack", 32'(bif.alloc_ack), 32'd1);
      check("cr_regrant_tag", 32'(bif.alloc_tag), 32'd0);
      tick();
      bif.alloc_req = 1'b0;
      check("cr_bcast_drop", 32'(bif.broadcast), 32'd0);
      check("cr_bm0_new", 32'(cob_data_s[0].branch_mask), 32'b0010);

      // Mispredict tag 1 with a competing allocation request
      do_reset();
      alloc_n(3);
      bif.alloc_req     = 1'b1;
      bif.resolve_valid = 1'b1;
      bif.resolve_tag   = 2'd1;
      bif.resolve_kill  = 1'b1;
      settle();
      check("mp_noack", 32'(bif.alloc_ack), 32'd0);
      tick();
      bif.resolve_valid = 1'b0;
      bif.resolve_kill  = 1'b0;
      check("mp_bcast", 32'(bif.broadcast), 32'd1);
      check("mp_kill", 32'(bif.kill), 32'd1);
      check("mp_tag", 32'(bif.tag), 32'd1);
      check("mp_live", 32'(bif.alloc_mask), 32'b0001);
      check("mp_bm1_kept", 32'(cob_data_s[1].branch_mask), 32'b0001);
      check("mp_full", 32'(bif.full), 32'd0);
      settle();
      check("mp_grant_tag", 32'(bif.alloc_tag), 32'd1);
      check("mp_grant_ack", 32'(bif.alloc_ack), 32'd1);
      tick();
      bif.alloc_req = 1'b0;
      check("mp_bcast_drop", 32'(bif.broadcast), 32'd0);
      check("mp_live2", 32'(bif.alloc_mask), 32'b0011);
      check("mp_bm1_new", 32'(cob_data_s[1].branch_mask), 32'b0001);

      // Resolve of a non-busy tag is ignored
      bif.resolve_valid = 1'b1;
      bif.resolve_tag   = 2'd3;
      bif.resolve_kill  = 1'b1;
      tick();
      bif.resolve_valid = 1'b0;
      bif.resolve_kill  = 1'b0;
      check("nb_bcast", 32'(bif.broadcast), 32'd0);
      check("nb_live", 32'(bif.alloc_mask), 32'b0011);

      // CDB snoop on a stored snapshot
      do_reset();
      alloc_n(1);
      check("snp_pre_valid", 32'(cob_data_s[0].rat_data[5].valid), 32'd0);
      check("snp_pre_data", 32'(cob_data_s[0].rat_data[5].data), 32'd7);
      cdb_valid = 1'b1;
      cdb_ard   = 5'd5;
      cdb_prd   = 6'd7;
      tick();
      cdb_valid = 1'b0;
`ifdef CHECKPOINT_CDB_SNOOP_EN
      check("snp_valid", 32'(cob_data_s[0].rat_data[5].valid), 32'd1);
`else
      check("snp_valid", 32'(cob_data_s[0].rat_data[5].valid), 32'd0);
`endif

      // Reset mid-operation with a broadcast pending
      do_reset();
      alloc_n(3);
      bif.resolve_valid = 1'b1;
      bif.resolve_tag   = 2'd0;
      bif.resolve_kill  = 1'b0;
      tick();
      check("mr_pending", 32'(bif.broadcast), 32'd1);
      bif.resolve_tag  = 2'd2;
      bif.resolve_kill = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_inputs();
      settle();
      check("mr_bcast", 32'(bif.broadcast), 32'd0);
      check("mr_full", 32'(bif.full), 32'd0);
      check("mr_live", 32'(bif.alloc_mask), 32'd0);
      check("mr_bm2", 32'(cob_data_s[2].branch_mask), 32'd0);
      bif.alloc_req = 1'b1;
      settle();
      check("mr_grant_tag", 32'(bif.alloc_tag), 32'd0);
      check("mr_grant_ack", 32'(bif.alloc_ack), 32'd1);
      bif.alloc_req = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
